icache_fetch: RTL and testbench

- Direct-mapped, read-only instruction cache between the CPU fetch address and a slower 16-bit external instruction memory.
- Returns a 32-bit instruction on a hit in the same cycle.
- On a miss it asserts stall, refills the whole line over a req/ack halfword bus, then serves the hit.
- The pipeline uses stall to extend the fetch stage.

---
 rtl/icache_fetch.sv | 179 +++++++++++++++++
 tb/tb_icache_fetch.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_fetch.sv
// Direct-mapped read-only instruction cache refilled over a 16-bit req/ack halfword bus.
// Optional hit/miss statistics counters are built when ICACHE_STATS_EN is defined.
module icache_fetch #(
   parameter int LINES = 16,
   parameter int WORDS = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        fetch_valid,
   input  logic [31:0] addr,
   input  logic        inv,
   output logic [31:0] instr,
   output logic        hit,
   output logic        stall,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ack,
   input  logic [15:0] mem_rdata
`ifdef ICACHE_STATS_EN
   ,
   output logic [31:0] hit_cnt,
   output logic [31:0] miss_cnt
`endif
);

   localparam int OFF_W    = $clog2(WORDS);
   localparam int OFF_WX   = (OFF_W > 0) ? OFF_W : 1;
   localparam int IDX_W    = $clog2(LINES);
   localparam int LINE_LSB = 2 + OFF_W;
   localparam int TAG_W    = 32 - LINE_LSB - IDX_W;
   localparam int K_W      = $clog2(2 * WORDS);

   localparam logic [K_W-1:0]   K_LAST    = K_W'(2 * WORDS - 1);
   localparam logic [31:0]      LINE_MASK = (32'd1 << LINE_LSB) - 32'd1;
   localparam logic [LINES-1:0] ONE_L     = LINES'(1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REFILL  = 2'd1,
      ST_INSTALL = 2'd2
   } state_t;

   state_t            state_q;
   logic [LINES-1:0]  valid_q;
   logic [LINES-1:0]  valid_d;
   logic [TAG_W-1:0]  tag_q  [LINES];
   logic [31:0]       data_q [LINES][WORDS];
   logic [31:0]       base_q;
   logic [K_W-1:0]    k_q;
   logic              mem_req_q;
   logic [31:0]       mem_addr_q;

   logic [OFF_WX-1:0] offset_s;
   logic [IDX_W-1:0]  index_s;
   logic [TAG_W-1:0]  tag_s;
   logic [IDX_W-1:0]  base_idx_s;
   logic [TAG_W-1:0]  base_tag_s;
   logic [OFF_WX-1:0] word_sel_s;
   logic [31:0]       line_base_s;
   logic              hit_s;
   logic              miss_s;
   logic [LINES-1:0]  install_mask_s;
   logic [LINES-1:0]  miss_mask_s;

   assign offset_s    = OFF_WX'((addr >> 2) & 32'(WORDS - 1));
   assign index_s     = IDX_W'(addr >> LINE_LSB);
   assign tag_s       = TAG_W'(addr >> (LINE_LSB + IDX_W));
   assign base_idx_s  = IDX_W'(base_q >> LINE_LSB);
   assign base_tag_s  = TAG_W'(base_q >> (LINE_LSB + IDX_W));
   assign word_sel_s  = OFF_WX'(k_q >> 1);
   assign line_base_s = addr & ~LINE_MASK;

   // Lookup: inv suppresses the hit in its own cycle, and nothing hits outside IDLE
   always_comb begin
      hit_s  = fetch_valid & valid_q[index_s] & (tag_q[index_s] == tag_s)
             & (state_q == ST_IDLE) & ~inv;
      miss_s = fetch_valid & ~hit_s & (state_q == ST_IDLE);
      if (hit_s) begin
         instr = data_q[index_s][offset_s];
      end else begin
         instr = 32'd0;
      end
      hit   = hit_s;
      stall = miss_s | (state_q != ST_IDLE);
   end

   // Valid update: a missing line is dropped while its data is overwritten; install wins over inv
   always_comb begin
      install_mask_s = (state_q == ST_INSTALL) ? (ONE_L << base_idx_s) : {LINES{1'b0}};
      miss_mask_s    = miss_s ? (ONE_L << index_s) : {LINES{1'b0}};
      if (inv) begin
         valid_d = install_mask_s;
      end else begin
         valid_d = (valid_q & ~miss_mask_s) | install_mask_s;
      end
   end

   assign mem_req  = mem_req_q;
   assign mem_addr = mem_addr_q;

   // Refill halfwords land straight in the line; it only becomes visible when valid is set
   always_ff @(posedge clk) begin
      if (rst && (state_q == ST_REFILL) && mem_ack) begin
         if (k_q[0]) begin
            data_q[base_idx_s][word_sel_s][31:16] <= mem_rdata;
         end else begin
            data_q[base_idx_s][word_sel_s][15:0] <= mem_rdata;
         end
      end
   end

`ifdef ICACHE_STATS_EN
   logic [31:0] hit_cnt_q;
   logic [31:0] miss_cnt_q;

   assign hit_cnt  = hit_cnt_q;
   assign miss_cnt = miss_cnt_q;

   // Saturating statistics; inv does not touch them
   always_ff @(posedge clk) begin
      if (!rst) begin
         hit_cnt_q  <= 32'd0;
         miss_cnt_q <= 32'd0;
      end else begin
         if (hit_s && (hit_cnt_q != 32'hFFFF_FFFF)) begin
            hit_cnt_q <= hit_cnt_q + 32'd1;
         end
         if (miss_s && (miss_cnt_q != 32'hFFFF_FFFF)) begin
            miss_cnt_q <= miss_cnt_q + 32'd1;
         end
      end
   end
`endif

   // Refill FSM with registered memory request and address
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         valid_q    <= {LINES{1'b0}};
         base_q     <= 32'd0;
         k_q        <= {K_W{1'b0}};
         mem_req_q  <= 1'b0;
         mem_addr_q <= 32'd0;
      end else begin
         valid_q <= valid_d;
         case (state_q)
            ST_IDLE: begin
               if (miss_s) begin
                  state_q    <= ST_REFILL;
                  base_q     <= line_base_s;
                  k_q        <= {K_W{1'b0}};
                  mem_req_q  <= 1'b1;
                  mem_addr_q <= line_base_s;
               end
            end
            ST_REFILL: begin
               if (mem_ack) begin
                  k_q <= k_q + K_W'(1);
                  if (k_q == K_LAST) begin
                     state_q   <= ST_INSTALL;
                     mem_req_q <= 1'b0;
                  end else begin
                     mem_addr_q <= mem_addr_q + 32'd2;
                  end
               end
            end
            ST_INSTALL: begin
               tag_q[base_idx_s] <= base_tag_s;
               state_q           <= ST_IDLE;
            end
            default: begin
               state_q   <= ST_IDLE;
               mem_req_q <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_icache_fetch.sv
// Directed self-checking bench for icache_fetch (LINES=16, WORDS=4) with a req/ack memory responder.
module tb_icache_fetch;

   logic        clk = 1'b0;
   logic        rst;
   logic        fetch_valid;
   logic [31:0] addr;
   logic        inv;
   logic [31:0] instr;
   logic        hit;
   logic        stall;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack;
   logic [15:0] mem_rdata;
`ifdef ICACHE_STATS_EN
   logic [31:0] hit_cnt;
   logic [31:0] miss_cnt;
`endif

   int          checks = 0;
   int          failures = 0;
   int          ack_delay = 0;
   int          unstable = 0;
   logic [31:0] addr_log[$];

   always #5 clk = ~clk;

   icache_fetch #(.LINES(16), .WORDS(4)) dut (
      .clk(clk), .rst(rst), .fetch_valid(fetch_valid), .addr(addr), .inv(inv),
      .instr(instr), .hit(hit), .stall(stall),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
`ifdef ICACHE_STATS_EN
      , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
   );

   // Memory: halfword at byte a is a[15:0]^16'hA5A5, ack after ack_delay waiting cycles
   initial begin : responder
      int          cnt;
      bit          pend;
      logic [31:0] pend_addr;
      mem_ack = 1'b0; mem_rdata = 16'd0; cnt = 0; pend = 1'b0; pend_addr = 32'd0;
      forever begin
         @(posedge clk);
         #1;
         if (rst !== 1'b1) begin
            mem_ack = 1'b0; cnt = 0; pend = 1'b0;
         end else if (mem_ack) begin
            mem_ack = 1'b0; cnt = 0; pend = 1'b0;
         end else if (mem_req) begin
            if (pend && (mem_addr !== pend_addr)) unstable++;
            pend = 1'b1;
            pend_addr = mem_addr;
            if (cnt >= ack_delay) begin
               mem_ack = 1'b1;
               mem_rdata = mem_addr[15:0] ^ 16'hA5A5;
               addr_log.push_back(mem_addr);
            end else begin
               cnt++;
            end
         end else begin
            cnt = 0; pend = 1'b0;
         end
      end
   end

   initial begin : watchdog
      #300000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic set_fetch(input logic v, input logic [31:0] a);
      @(negedge clk);
      fetch_valid = v;
      addr = a;
      #1;
   endtask

   task automatic wait_hit(input string tag, input int budget, output int cyc);
      int stall_bad;
      stall_bad = 0;
      cyc = 0;
      while ((hit !== 1'b1) && (cyc < budget)) begin
         @(negedge clk);
         cyc++;
         if ((hit !== 1'b1) && (stall !== 1'b1)) stall_bad++;
      end
      chk({tag, "_hit"}, 32'(hit), 32'd1);
      chk({tag, "_stall_held"}, 32'(stall_bad), 32'd0);
   endtask

   task automatic wait_log(input string tag, input int n, input int budget);
      int cyc;
      cyc = 0;
      while ((addr_log.size() < n) && (cyc < budget)) begin
         @(negedge clk);
         cyc++;
      end
      chk({tag, "_acks_seen"}, 32'(addr_log.size() >= n), 32'd1);
   endtask

   task automatic check_line(input string tag, input int first, input logic [31:0] base);
      for (int k = 0; k < 8; k++) begin
         if (first + k < addr_log.size())
            chk($sformatf("%s_mem_addr%0d", tag, k), addr_log[first + k], base + 32'(2 * k));
         else
            chk($sformatf("%s_mem_addr%0d_missing", tag, k), 32'd0, 32'd1);
      end
   endtask

   initial begin : stimulus
      int          cyc;
      logic [31:0] line_addrs [3];
      logic [31:0] line_instr [3];
      line_addrs = '{32'h14, 32'h18, 32'h1C};
      line_instr = '{32'hA5B3A5B1, 32'hA5BFA5BD, 32'hA5BBA5B9};

      rst = 1'b0; fetch_valid = 1'b0; addr = 32'd0; inv = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_hit", 32'(hit), 32'd0);
      chk("reset_stall", 32'(stall), 32'd0);
      chk("reset_mem_req", 32'(mem_req), 32'd0);
      chk("reset_mem_addr", mem_addr, 32'd0);
      chk("reset_instr", instr, 32'd0);
      rst = 1'b1;

      // cold miss
      addr_log.delete();
      set_fetch(1'b1, 32'h10);
      chk("cold_first_hit", 32'(hit), 32'd0);
      chk("cold_first_stall", 32'(stall), 32'd1);
      wait_hit("cold", 100, cyc);
      chk("cold_latency", 32'(cyc), 32'd17);
      chk("cold_instr", instr, 32'hA5B7A5B5);
      chk("cold_stall_after", 32'(stall), 32'd0);
      chk("cold_req_after", 32'(mem_req), 32'd0);
      chk("cold_refill_len", 32'(addr_log.size()), 32'd8);
      check_line("cold", 0, 32'h10);

      // hits within the line
      addr_log.delete();
      for (int i = 0; i < 3; i++) begin
         set_fetch(1'b1, line_addrs[i]);
         chk($sformatf("line_hit%0d", i), 32'(hit), 32'd1);
         chk($sformatf("line_instr%0d", i), instr, line_instr[i]);
         chk($sformatf("line_stall%0d", i), 32'(stall), 32'd0);
         chk($sformatf("line_req%0d", i), 32'(mem_req), 32'd0);
      end
      @(negedge clk);
      chk("line_no_refill", 32'(addr_log.size()), 32'd0);

      // conflict: 0x110 evicts 0x10, then 0x10 again
      set_fetch(1'b1, 32'h110);
      chk("conf_a_miss", 32'(hit), 32'd0);
      wait_hit("conf_a", 100, cyc);
      chk("conf_a_instr", instr, 32'hA4B7A4B5);
      chk("conf_a_len", 32'(addr_log.size()), 32'd8);
      check_line("conf_a", 0, 32'h110);
      addr_log.delete();
      set_fetch(1'b1, 32'h10);
      chk("conf_b_miss", 32'(hit), 32'd0);
      wait_hit("conf_b", 100, cyc);
      chk("conf_b_instr", instr, 32'hA5B7A5B5);
      chk("conf_b_len", 32'(addr_log.size()), 32'd8);
      check_line("conf_b", 0, 32'h10);
      addr_log.delete();

      // inv while idle on a valid line: hit suppressed, then refill under backpressure
      ack_delay = 3;
      @(negedge clk);
      fetch_valid = 1'b1; addr = 32'h10; inv = 1'b1;
      #1;
      chk("inv_suppress_hit", 32'(hit), 32'd0);
      chk("inv_suppress_stall", 32'(stall), 32'd1);
      @(negedge clk);
      inv = 1'b0;
      wait_log("bp", 2, 100);
      set_fetch(1'b1, 32'h40);
      wait_hit("bp", 600, cyc);
      chk("bp_instr", instr, 32'hA5E7A5E5);
      chk("bp_len", 32'(addr_log.size()), 32'd16);
      check_line("bp_first", 0, 32'h10);
      check_line("bp_second", 8, 32'h40);
      chk("bp_addr_stable", 32'(unstable), 32'd0);
      set_fetch(1'b1, 32'h10);
      chk("bp_old_line_hit", 32'(hit), 32'd1);
      chk("bp_old_line_instr", instr, 32'hA5B7A5B5);
      ack_delay = 0;

      // invalidate during a refill while 0x20 is valid
      set_fetch(1'b1, 32'h110);
      wait_hit("inv_prep_a", 100, cyc);
      set_fetch(1'b1, 32'h20);
      wait_hit("inv_prep_b", 100, cyc);
      chk("inv_prep_instr", instr, 32'hA587A585);
      addr_log.delete();
      set_fetch(1'b1, 32'h10);
      wait_log("inv", 3, 100);
      @(negedge clk);
      inv = 1'b1;
      @(negedge clk);
      inv = 1'b0;
      wait_hit("inv_fill", 100, cyc);
      chk("inv_fill_instr", instr, 32'hA5B7A5B5);
      chk("inv_fill_len", 32'(addr_log.size()), 32'd8);
      check_line("inv_fill", 0, 32'h10);
      addr_log.delete();
      set_fetch(1'b1, 32'h20);
      chk("inv_other_miss", 32'(hit), 32'd0);
      wait_hit("inv_refetch", 100, cyc);
      chk("inv_refetch_instr", instr, 32'hA587A585);
      check_line("inv_refetch", 0, 32'h20);

      // reset in the middle of a refill
      set_fetch(1'b1, 32'h110);
      wait_hit("rst_prep", 100, cyc);
      addr_log.delete();
      set_fetch(1'b1, 32'h10);
      wait_log("rst", 3, 100);
      @(negedge clk);
      chk("rst_pre_req", 32'(mem_req), 32'd1);
      rst = 1'b0;
      fetch_valid = 1'b0;
      @(negedge clk);
      chk("rst_mid_req", 32'(mem_req), 32'd0);
      chk("rst_mid_addr", mem_addr, 32'd0);
      chk("rst_mid_stall", 32'(stall), 32'd0);
      chk("rst_mid_hit", 32'(hit), 32'd0);
      rst = 1'b1;
      addr_log.delete();
      fetch_valid = 1'b1;
      addr = 32'h10;
      #1;
      chk("rst_restart_miss", 32'(hit), 32'd0);
      wait_hit("rst_restart", 100, cyc);
      chk("rst_restart_instr", instr, 32'hA5B7A5B5);
      chk("rst_restart_len", 32'(addr_log.size()), 32'd8);
      check_line("rst_restart", 0, 32'h10);
`ifdef ICACHE_STATS_EN
      chk("rst_miss_cnt", miss_cnt, 32'd1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
